// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro: DATAMEM_ARB_RR_EN (round-robin tie break).
package datamem_arb_pkg;

  localparam int DMA_ADDR_W = 7;
  localparam int DMA_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  // The port that did not take the previous grant.
  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/datamem_arbiter_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// With DATAMEM_ARB_RR_EN defined a tie goes to the port not served last;
// otherwise port A always wins a tie.
module arb_pick
  import datamem_arb_pkg::*;
(
  input  logic     a_req,
  input  logic     b_req,
  input  port_id_t last_served,
  output logic     valid,
  output port_id_t winner
);

`ifndef DATAMEM_ARB_RR_EN
  // Fixed priority ignores history; keep the input visibly consumed.
  logic w_unused_last_served;
  assign w_unused_last_served = last_served;
`endif

  // Pick the winner among the active requests.
  always_comb begin
    valid = a_req | b_req;
    if (a_req && b_req) begin
`ifdef DATAMEM_ARB_RR_EN
      winner = other_port(last_served);
`else
      winner = PORT_A;
`endif
    end else if (b_req) begin
      winner = PORT_B;
    end else begin
      winner = PORT_A;
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// IDLE samples requests, ACCESS drives the memory for one cycle with the
// owner's grant, RESP returns read data (memory has 1-cycle read latency).
// Optional feature macro: DATAMEM_ARB_RR_EN (round-robin tie break).
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  port_id_t          r_owner;
  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic              w_valid;
  port_id_t          w_winner;
  port_id_t          w_last_served;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  arb_pick u_arb_pick (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_served (w_last_served),
    .valid       (w_valid),
    .winner      (w_winner)
  );

`ifdef DATAMEM_ARB_RR_EN
  port_id_t r_last_served;
  assign w_last_served = r_last_served;

  // Remember which port took the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_served <= PORT_B;
    end else if ((r_state == IDLE) && w_valid) begin
      r_last_served <= w_winner;
    end
  end
`else
  assign w_last_served = PORT_B;
`endif

  // Route the winning requester's command toward the latch.
  always_comb begin
    if (w_winner == PORT_B) begin
      w_sel_we    = b_we;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
    end else begin
      w_sel_we    = a_we;
      w_sel_addr  = a_addr;
      w_sel_wdata = a_wdata;
    end
  end

  // Arbiter FSM: latch the winner, drive memory, return read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= PORT_A;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_mem_we   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner     <= w_winner;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we    <= w_sel_we;
            r_a_gnt     <= (w_winner == PORT_A);
            r_b_gnt     <= (w_winner == PORT_B);
            r_state     <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          // r_mem_we still holds the latched direction during ACCESS.
          if (r_mem_we) begin
            r_state <= IDLE;
          end else begin
            r_a_rvalid <= (r_owner == PORT_A);
            r_b_rvalid <= (r_owner == PORT_B);
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (r_owner == PORT_B) begin
            r_b_rdata <= mem_rdata;
          end else begin
            r_a_rdata <= mem_rdata;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a_gnt     = r_a_gnt;
  assign b_gnt     = r_b_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Memory read data only exists during RESP, so the owner sees it directly
  // then; afterwards each port holds the last word it was given.
  assign a_rdata = r_a_rvalid ? mem_rdata : r_a_rdata;
  assign b_rdata = r_b_rvalid ? mem_rdata : r_b_rdata;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_datamem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
`ifdef DATAMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  logic          mem_clr;

  datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory with registered read data.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    dly;
  } cmd_t;

  typedef struct packed {
    logic          a_gnt;
    logic          b_gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          a_rv;
    logic          b_rv;
    logic [DW-1:0] rdata;
  } exp_t;

  cmd_t q_a[$], q_b[$];
  exp_t slot[4];
  logic [DW-1:0] ref_mem [128];
  int   cyc, free_cyc, n_checks, n_fail;
  logic act_a, act_b, m_last_b;
  logic pend_w;
  int   pend_cyc;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data, m_rd_a, m_rd_b, last_a_rv, last_b_rv;
  int   gnt_log[$], a_gnt_cycs[$];
  int   last_b_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] d, input logic [7:0] dly);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = d; c.dly = dly;
    return c;
  endfunction

  function automatic logic [1:0] sl(input int c);
    return 2'(c);
  endfunction

  // One clock cycle: check outputs, advance requesters, predict the future.
  task automatic step();
    exp_t s;
    cmd_t h;
    logic pick_b;
    @(negedge clk);
    cyc++;
    if (pend_w && cyc >= pend_cyc) begin
      ref_mem[pend_addr] = pend_data;
      pend_w = 1'b0;
    end
    s = slot[sl(cyc)];
    check("a_gnt", 32'(a_gnt), 32'(s.a_gnt));
    check("b_gnt", 32'(b_gnt), 32'(s.b_gnt));
    check("mem_we", 32'(mem_we), 32'(s.we));
    if (s.a_gnt || s.b_gnt) begin
      check("mem_addr", 32'(mem_addr), 32'(s.addr));
      check("mem_wdata", mem_wdata, s.wdata);
    end
    check("a_rvalid", 32'(a_rvalid), 32'(s.a_rv));
    check("b_rvalid", 32'(b_rvalid), 32'(s.b_rv));
    if (s.a_rv) m_rd_a = s.rdata;
    if (s.b_rv) m_rd_b = s.rdata;
    check("a_rdata", a_rdata, m_rd_a);
    check("b_rdata", b_rdata, m_rd_b);
    if (a_gnt) begin gnt_log.push_back(0); a_gnt_cycs.push_back(cyc); end
    if (b_gnt) begin gnt_log.push_back(1); last_b_gnt = cyc; end
    if (a_rvalid) last_a_rv = a_rdata;
    if (b_rvalid) last_b_rv = b_rdata;

    // Requesters hold until the grant cycle, then move to the next command.
    if (s.a_gnt && act_a) begin void'(q_a.pop_front()); act_a = 1'b0; end
    if (s.b_gnt && act_b) begin void'(q_b.pop_front()); act_b = 1'b0; end
    if (!act_a && q_a.size() > 0) begin
      if (q_a[0].dly > 8'd0) begin h = q_a[0]; h.dly--; q_a[0] = h; end
      else act_a = 1'b1;
    end
    if (!act_b && q_b.size() > 0) begin
      if (q_b[0].dly > 8'd0) begin h = q_b[0]; h.dly--; q_b[0] = h; end
      else act_b = 1'b1;
    end
    a_req = act_a;
    b_req = act_b;
    if (act_a) begin a_we = q_a[0].we; a_addr = q_a[0].addr; a_wdata = q_a[0].wdata; end
    else begin a_we = 1'($urandom); a_addr = 7'($urandom); a_wdata = $urandom; end
    if (act_b) begin b_we = q_b[0].we; b_addr = q_b[0].addr; b_wdata = q_b[0].wdata; end
    else begin b_we = 1'($urandom); b_addr = 7'($urandom); b_wdata = $urandom; end

    // Transaction model: a free arbiter serves one request per sample.
    if (cyc >= free_cyc && (act_a || act_b)) begin
      if (act_a && act_b) pick_b = RR ? !m_last_b : 1'b0;
      else pick_b = act_b;
      h = pick_b ? q_b[0] : q_a[0];
      m_last_b = pick_b;
      slot[sl(cyc + 1)].a_gnt = !pick_b;
      slot[sl(cyc + 1)].b_gnt = pick_b;
      slot[sl(cyc + 1)].we    = h.we;
      slot[sl(cyc + 1)].addr  = h.addr;
      slot[sl(cyc + 1)].wdata = h.wdata;
      if (h.we) begin
        pend_w = 1'b1; pend_cyc = cyc + 2; pend_addr = h.addr; pend_data = h.wdata;
        free_cyc = cyc + 2;
      end else begin
        slot[sl(cyc + 2)].a_rv  = !pick_b;
        slot[sl(cyc + 2)].b_rv  = pick_b;
        slot[sl(cyc + 2)].rdata = ref_mem[h.addr];
        free_cyc = cyc + 3;
      end
    end
    slot[sl(cyc)] = '0;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while ((q_a.size() > 0 || q_b.size() > 0 || cyc <= free_cyc) && n < max) begin
      step();
      n++;
    end
    if (n >= max) check("drain_timeout", 32'(n), 32'(max - 1));
  endtask

  task automatic model_reset();
    q_a.delete(); q_b.delete();
    act_a = 1'b0; act_b = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 4; i++) slot[i] = '0;
    free_cyc = 0; pend_w = 1'b0; m_last_b = 1'b1;
    m_rd_a = '0; m_rd_b = '0;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear at once.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_a_gnt", 32'(a_gnt), 32'd0);
    check("rst_b_gnt", 32'(b_gnt), 32'd0);
    check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int exp_order [4];
    n_checks = 0; n_fail = 0; cyc = 0; last_b_gnt = 0;
    last_a_rv = '0; last_b_rv = '0;
    a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    apply_reset();
    mem_clr = 1'b0;

    // Tie: both ports hold requests for four writes each.
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(mk(1'b1, 7'(20 + i), 32'hA000_0000 + 32'(i), 8'd0));
      q_b.push_back(mk(1'b1, 7'(40 + i), 32'hB000_0000 + 32'(i), 8'd0));
    end
    run_until_idle(100);
    for (int i = 0; i < 4; i++) begin
      exp_order[i] = (RR && (i % 2 == 1)) ? 1 : 0;
      check("tie_order", 32'((i < gnt_log.size()) ? gnt_log[i] : 9), 32'(exp_order[i]));
    end

    // Port A write then read back.
    q_a.push_back(mk(1'b1, 7'd5, 32'hDEAD_BEEF, 8'd0));
    q_a.push_back(mk(1'b0, 7'd5, 32'h0, 8'd0));
    run_until_idle(50);
    check("a_readback", last_a_rv, 32'hDEAD_BEEF);

    // Port B alone at the top address; A must stay silent.
    gnt_log.delete();
    q_b.push_back(mk(1'b1, 7'd127, 32'h0000_1234, 8'd0));
    q_b.push_back(mk(1'b0, 7'd127, 32'h0, 8'd0));
    run_until_idle(50);
    n = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 0) n++;
    check("b_alone_a_gnts", 32'(n), 32'd0);
    check("b_readback", last_b_rv, 32'h0000_1234);

    // B raises its request while A's read is in ACCESS.
    a_gnt_cycs.delete();
    q_a.push_back(mk(1'b0, 7'd5, 32'h0, 8'd0));
    q_b.push_back(mk(1'b0, 7'd127, 32'h0, 8'd1));
    run_until_idle(50);
    check("busy_gap", 32'((a_gnt_cycs.size() > 0) ? last_b_gnt - a_gnt_cycs[0] : -1), 32'd3);

    // Back-to-back writes from A: one grant every two cycles.
    a_gnt_cycs.delete();
    for (int i = 0; i < 4; i++) q_a.push_back(mk(1'b1, 7'(60 + i), $urandom, 8'd0));
    run_until_idle(50);
    for (int i = 1; i < 4; i++)
      check("b2b_gap", 32'((i < a_gnt_cycs.size()) ? a_gnt_cycs[i] - a_gnt_cycs[i-1] : -1), 32'd2);

    // Reset during the ACCESS of a write must not commit it.
    q_a.push_back(mk(1'b1, 7'd9, 32'h0000_0011, 8'd0));
    run_until_idle(50);
    a_gnt_cycs.delete();
    q_a.push_back(mk(1'b1, 7'd9, 32'h0000_0055, 8'd0));
    n = 0;
    while (a_gnt_cycs.size() == 0 && n < 10) begin step(); n++; end
    check("rst_write_granted", 32'(a_gnt_cycs.size()), 32'd1);
    apply_reset();
    repeat (4) step();
    q_a.push_back(mk(1'b0, 7'd9, 32'h0, 8'd0));
    run_until_idle(50);
    check("rst_old_value", last_a_rv, 32'h0000_0011);

    // Random mixed traffic on both ports.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0)
        q_a.push_back(mk(1'($urandom), 7'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 3))));
      else
        q_b.push_back(mk(1'($urandom), 7'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 3))));
    end
    run_until_idle(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
